// File: rtl/cpu_mul_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_mul_pkg
// Purpose  : Shared types and helpers for the M-stage multiply combine logic.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mul_pkg;

  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mulx_state_t;

  // Amount to subtract from the unsigned high word to obtain the signed one.
  function automatic logic [31:0] mulx_sign_fix(input mul_op_t     op,
                                                input logic [31:0] src1,
                                                input logic [31:0] src2);
    logic [31:0] fix;
    fix = '0;
    if (((op == MULXSU) || (op == MULXSS)) && src1[31]) fix = fix + src2;
    if ((op == MULXSS) && src2[31])                      fix = fix + src1;
    return fix;
  endfunction

endpackage
`default_nettype wire

// File: rtl/practical_nios_nios2_gen2_0_cpu_mul_hi_seq.sv
`default_nettype none
// ============================================================================
// Module   : practical_nios_nios2_gen2_0_cpu_mul_hi_seq
// Purpose  : Sequential shift-add forming the 16x16 unsigned hi*hi product.
// Revision : 1.0 - initial release
// ============================================================================
module practical_nios_nios2_gen2_0_cpu_mul_hi_seq
  import cpu_mul_pkg::*;
#(
  parameter int ITERS = HALF_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [HALF_W-1:0]   mcand,
  input  logic [HALF_W-1:0]   mplier,
  output logic                busy,
  output logic                last,
  output logic [2*HALF_W-1:0] product
);

  localparam int CNT_W  = $clog2(ITERS);
  localparam int PROD_W = 2 * HALF_W;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic [PROD_W-1:0] addend;

  assign last    = (cnt_q == CNT_W'(ITERS - 1));
  assign addend  = PROD_W'(mcand) << cnt_q;
  assign busy    = busy_q;
  assign product = acc_q;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (mplier[cnt_q]) acc_d = acc_q + addend;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/practical_nios_nios2_gen2_0_cpu_mul_combine.sv
`default_nettype none
// ============================================================================
// Module   : practical_nios_nios2_gen2_0_cpu_mul_combine
// Purpose  : Combines registered 16x16 partial products into the MUL low word
//            and, when MUL_COMBINE_MULX_EN is defined, the MULX high word.
// Revision : 1.0 - initial release
// ============================================================================
module practical_nios_nios2_gen2_0_cpu_mul_combine
  import cpu_mul_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_en,
  input  logic        E_mul_valid,
  input  logic [1:0]  E_mul_op,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic        M_mul_stall,
  output logic        A_mul_done,
  output logic [31:0] A_mul_result
);

  logic        m_valid_q, m_valid_d;
  logic        consumed_q, consumed_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        capture;
  logic [32:0] mid;
  logic [32:0] lo_sum;
  logic [31:0] lo;
  logic        c_lo;

  assign mid     = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
  assign lo_sum  = {1'b0, M_mul_cell_p1} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
  assign lo      = lo_sum[31:0];
  assign c_lo    = lo_sum[32];
  // A stalled M stage never re-captures, even if M_en is wrongly raised.
  assign capture = M_en & ~M_mul_stall;

  assign A_mul_done   = done_q;
  assign A_mul_result = result_q;

`ifdef MUL_COMBINE_MULX_EN

  mul_op_t           m_op_q, m_op_d;
  logic [31:0]       m_src1_q, m_src1_d;
  logic [31:0]       m_src2_q, m_src2_d;
  mulx_state_t       state_q, state_d;
  logic [HALF_W+1:0] hi_base_q, hi_base_d;
  logic              mul_pending;
  logic              mulx_pending;
  logic              seq_start;
  logic              seq_busy;
  logic              seq_last;
  logic [31:0]       seq_product;

  assign mul_pending  = m_valid_q & ~consumed_q;
  assign mulx_pending = mul_pending & (m_op_q != MUL);
  assign M_mul_stall  = mulx_pending;

  practical_nios_nios2_gen2_0_cpu_mul_hi_seq #(
    .ITERS   (ITERS)
  ) u_hi_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (seq_start),
    .mcand   (m_src1_q[31:HALF_W]),
    .mplier  (m_src2_q[31:HALF_W]),
    .busy    (seq_busy),
    .last    (seq_last),
    .product (seq_product)
  );

  always_comb begin
    m_valid_d  = m_valid_q;
    m_op_d     = m_op_q;
    m_src1_d   = m_src1_q;
    m_src2_d   = m_src2_q;
    consumed_d = consumed_q;
    done_d     = 1'b0;
    result_d   = result_q;
    state_d    = state_q;
    hi_base_d  = hi_base_q;
    seq_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mulx_pending) begin
          // Carry of the cross terms into the high word, taken while p1..p3 are valid.
          hi_base_d = (HALF_W+2)'(mid[32:HALF_W]) + (HALF_W+2)'(c_lo);
          seq_start = 1'b1;
          state_d   = ITER;
        end else if (mul_pending) begin
          done_d     = 1'b1;
          result_d   = lo;
          consumed_d = 1'b1;
        end
      end
      ITER: begin
        if (seq_busy && seq_last) state_d = FIX;
      end
      FIX: begin
        result_d   = seq_product + 32'(hi_base_q)
                   - mulx_sign_fix(m_op_q, m_src1_q, m_src2_q);
        done_d     = 1'b1;
        consumed_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      m_valid_d  = E_mul_valid;
      m_op_d     = mul_op_t'(E_mul_op);
      m_src1_d   = E_src1;
      m_src2_d   = E_src2;
      consumed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_valid_q  <= 1'b0;
      m_op_q     <= MUL;
      m_src1_q   <= '0;
      m_src2_q   <= '0;
      consumed_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      state_q    <= IDLE;
      hi_base_q  <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_op_q     <= m_op_d;
      m_src1_q   <= m_src1_d;
      m_src2_q   <= m_src2_d;
      consumed_q <= consumed_d;
      done_q     <= done_d;
      result_q   <= result_d;
      state_q    <= state_d;
      hi_base_q  <= hi_base_d;
    end
  end

`else

  // Without the high-word option every op retires as a plain MUL.
  logic unused_inputs;
  assign unused_inputs = ^{E_mul_op, E_src1, E_src2, mid[32:HALF_W], c_lo, 32'(ITERS)};
  assign M_mul_stall   = 1'b0;

  always_comb begin
    m_valid_d  = m_valid_q;
    consumed_d = consumed_q;
    done_d     = 1'b0;
    result_d   = result_q;

    if (m_valid_q && !consumed_q) begin
      done_d     = 1'b1;
      result_d   = lo;
      consumed_d = 1'b1;
    end

    if (capture) begin
      m_valid_d  = E_mul_valid;
      consumed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_valid_q  <= 1'b0;
      consumed_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      consumed_q <= consumed_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_practical_nios_nios2_gen2_0_cpu_mul_combine.sv
`default_nettype none
// ============================================================================
// Module   : tb_practical_nios_nios2_gen2_0_cpu_mul_combine
// Purpose  : Self-checking bench; expectations come from 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_practical_nios_nios2_gen2_0_cpu_mul_combine;

`ifdef MUL_COMBINE_MULX_EN
  localparam bit MULX_ON = 1'b1;
`else
  localparam bit MULX_ON = 1'b0;
`endif
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_en = 1'b0;
  logic        E_mul_valid = 1'b0;
  logic [1:0]  E_mul_op = '0;
  logic [31:0] E_src1 = '0;
  logic [31:0] E_src2 = '0;
  logic [31:0] M_mul_cell_p1 = '0;
  logic [31:0] M_mul_cell_p2 = '0;
  logic [31:0] M_mul_cell_p3 = '0;
  logic        M_mul_stall;
  logic        A_mul_done;
  logic [31:0] A_mul_result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  practical_nios_nios2_gen2_0_cpu_mul_combine #(
    .ITERS         (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .E_mul_valid   (E_mul_valid),
    .E_mul_op      (E_mul_op),
    .E_src1        (E_src1),
    .E_src2        (E_src2),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .M_mul_stall   (M_mul_stall),
    .A_mul_done    (A_mul_done),
    .A_mul_result  (A_mul_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full 64-bit product with the operand signedness of each op.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, prod;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (!MULX_ON || op == 2'd0) begin
      prod = ua * ub;
      return prod[31:0];
    end
    case (op)
      2'd1:    prod = ua * ub;
      2'd2:    prod = sa * ub;
      default: prod = sa * sb;
    endcase
    return prod[63:32];
  endfunction

  function automatic int ref_latency(input logic [1:0] op);
    return (MULX_ON && op != 2'd0) ? 18 : 1;
  endfunction

  task automatic set_products(input logic [31:0] a, input logic [31:0] b);
    M_mul_cell_p1 = 32'(a[15:0]) * 32'(b[15:0]);
    M_mul_cell_p2 = 32'(a[15:0]) * 32'(b[31:16]);
    M_mul_cell_p3 = 32'(a[31:16]) * 32'(b[15:0]);
  endtask

  // Called just after a falling edge; returns just after the falling edge of
  // the done cycle (plus hold cycles) so the next op can enter immediately.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    int          lat;
    bit          seen;
    exp  = ref_result(op, a, b);
    lat  = ref_latency(op);
    seen = 1'b0;
    check_eq("men_vs_stall", {31'b0, M_mul_stall}, 32'd0);
    E_mul_valid = 1'b1;
    E_mul_op    = op;
    E_src1      = a;
    E_src2      = b;
    M_en        = 1'b1;
    @(posedge clk);
    #1;
    M_en        = 1'b0;
    E_mul_valid = 1'b0;
    E_mul_op    = 2'($urandom);
    E_src1      = $urandom;
    E_src2      = $urandom;
    set_products(a, b);
    for (int k = 0; k < BUDGET && !seen; k++) begin
      @(negedge clk);
      check_eq("stall", {31'b0, M_mul_stall}, {31'b0, (MULX_ON && op != 2'd0 && k <= 17)});
      if (A_mul_done) begin
        seen = 1'b1;
        check_eq("latency", 32'(k), 32'(lat));
        check_eq("result", A_mul_result, exp);
        last_result = exp;
      end
    end
    check_eq("done_seen", {31'b0, seen}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_no_done", {31'b0, A_mul_done}, 32'd0);
      check_eq("hold_result", A_mul_result, exp);
    end
  endtask

  task automatic run_nonmul();
    E_mul_valid = 1'b0;
    E_src1      = $urandom;
    E_src2      = $urandom;
    M_en        = 1'b1;
    @(posedge clk);
    #1;
    M_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("nonmul_done", {31'b0, A_mul_done}, 32'd0);
      check_eq("nonmul_stall", {31'b0, M_mul_stall}, 32'd0);
      check_eq("nonmul_result", A_mul_result, last_result);
    end
  endtask

  task automatic reset_mid_iter();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    E_mul_valid = 1'b1;
    E_mul_op    = 2'd3;
    E_src1      = a;
    E_src2      = b;
    M_en        = 1'b1;
    @(posedge clk);
    #1;
    M_en        = 1'b0;
    E_mul_valid = 1'b0;
    set_products(a, b);
    for (int k = 0; k <= 8; k++) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_done", {31'b0, A_mul_done}, 32'd0);
    check_eq("rst_mid_stall", {31'b0, M_mul_stall}, 32'd0);
    check_eq("rst_mid_result", A_mul_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check_eq("post_rst_done", {31'b0, A_mul_done}, 32'd0);
      check_eq("post_rst_stall", {31'b0, M_mul_stall}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_done", {31'b0, A_mul_done}, 32'd0);
    check_eq("rst_stall", {31'b0, M_mul_stall}, 32'd0);
    check_eq("rst_result", A_mul_result, 32'd0);
    reset_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(2'd0, 32'd3, 32'd5, 0);
    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    run_nonmul();
    run_op(2'd3, 32'h8000_0000, 32'h8000_0000, 1);
    run_op(2'd2, 32'h8000_0001, 32'h7FFF_FFFF, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 2));
    end

    reset_mid_iter();
    run_op(2'd1, $urandom, $urandom, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/practical_nios_nios2_gen2_0_cpu_mul_combine.md
# practical_nios_nios2_gen2_0_cpu_mul_combine

M-stage consumer of the three registered 16x16 partial products produced by the CPU multiplier cell. Every MUL retires its low 32-bit word in one cycle. With the high-word option compiled in, MULXUU/MULXSU/MULXSS also retire their high 32-bit word: a sequential 16-iteration shift-add forms hi*hi while the M stage is stalled. The result goes to the A/W writeback path.

## Interface
Parameters:
- ITERS, 16, shift-add iterations for the hi*hi product; fixed at the half-word width.

Ports:
- clk  in  1  CPU clock
- reset_n  in  1  synchronous, active-low reset
- M_en  in  1  pipeline advance; E→M capture happens only when high
- E_mul_valid  in  1  E-stage instruction is a multiply
- E_mul_op  in  2  0=MUL, 1=MULXUU, 2=MULXSU, 3=MULXSS
- E_src1, E_src2  in  32  operands, the same values the multiplier cell sees
- M_mul_cell_p1  in  32  src1[15:0]*src2[15:0], valid in M
- M_mul_cell_p2  in  32  src1[15:0]*src2[31:16], valid in M
- M_mul_cell_p3  in  32  src1[31:16]*src2[15:0], valid in M
- M_mul_stall  out  1  M must hold; the pipeline forces M_en low while this is high
- A_mul_done  out  1  one-cycle pulse: A_mul_result is valid
- A_mul_result  out  32  result word

## Operation
- Capture on M_en=1: m_valid←E_mul_valid; m_op, m_src1, m_src2 ←E values; the consumed flag clears.
- Low word, computed combinationally in M cycle 0:
  - mid = p2 + p3 (33 bits)
  - lo = p1 + {mid[15:0],16'h0}; c_lo = carry out of bit 31
- MUL:
  - A_mul_result←lo and A_mul_done pulses on the next edge.
  - consumed is set, so a held M stage (M_en low for another reason) does not pulse again.
- MULX FSM, states IDLE, ITER, FIX:
  - IDLE: m_valid & op≠0 & !consumed → latch hi_base = mid[32:16] + c_lo (18 bits); acc←0; cnt←0; go to ITER.
  - ITER: each cycle, if m_src2[16+cnt] then acc += {m_src1[31:16]} << cnt (32-bit acc); cnt++. Exit to FIX when cnt = ITERS-1.
  - FIX: hi = acc + hi_base, then subtract sign corrections mod 2^32:
    - subtract m_src2 if op∈{SU,SS} & m_src1[31]
    - subtract m_src1 if op=SS & m_src2[31]
  - FIX exit: A_mul_result←hi, A_mul_done pulses, consumed←1, return to IDLE.
- M_mul_stall = m_valid & op≠0 & !consumed & state≠FIX-complete, i.e. high from M cycle 0 through the FIX cycle.
- Non-multiply in M: no done pulse, no stall, A_mul_result holds its last value.

## Timing
- Reset values: every output is 0; FSM=IDLE; m_valid=0; consumed=0; acc=0; cnt=0.
- MUL latency: instruction in M at cycle 0 → done at cycle 1. Stall never asserted.
- MULX latency: stall high cycles 0–17 (IDLE 0, ITER 1–16, FIX 17); done and result at cycle 18. M_en must be low in cycles 0–17.
- Back-to-back: a MUL or MULX entering M in the cycle after done is accepted normally.
- M_en high while M_mul_stall is high is a protocol violation and the block ignores it; the bench checks that it never happens.
- Reset asserted mid-iteration: the next edge returns to the reset state; no done pulse; stall low.

## Configuration
- MUL_COMBINE_MULX_EN defined: FSM, shift-add and sign correction are present, behaving as above.
- MUL_COMBINE_MULX_EN undefined:
  - every op is treated as MUL (low word, 1-cycle latency).
  - M_mul_stall is tied 0; no FSM, acc, or cnt registers.

## Structure
- Shared package cpu_mul_pkg: the mul_op_t enum (MUL/MULXUU/MULXSU/MULXSS), the mulx_state_t enum (IDLE/ITER/FIX), and the constant HALF_W=16.
- One natural sub-module, practical_nios_nios2_gen2_0_cpu_mul_hi_seq: a 16x16 sequential shift-add with start, busy, and a 32-bit product. The top block keeps capture, the low word, correction and outputs.

## Test plan
- MUL, src1=src2=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) → cycle 1: done, result 0x00000001; stall never high.
- MULXUU, same operands → stall high cycles 0–17, done at cycle 18, result 0xFFFFFFFE.
- MULXSU and MULXSS, same operands → results 0xFFFFFFFF and 0x00000000 respectively.
- MULXUU, 0x00010000 × 0x00010000 → result 0x00000001; then an immediate MUL, 3×5 → 0x0000000F at its cycle 1.
- Hold after done: MUL with M_en held low for 5 further cycles → exactly one done pulse.
- Reset at ITER cycle 8 of a MULXSS → stall and done are 0 the next cycle, FSM is IDLE, and no stale result is ever produced.
